// File: rtl/rs_parity_lfsr_pkg.sv
// Shared Reed-Solomon definitions: FSM states, field polynomials, GF multiply and
// generator-polynomial construction (roots alpha^0 .. alpha^(n-1)).
package rs_parity_lfsr_pkg;

    typedef enum logic {
        ST_MSG = 1'b0,
        ST_PAR = 1'b1
    } rs_state_e;

    localparam logic [8:0] RS_PLY_GF256 = 9'h11D;
    localparam logic [4:0] RS_PLY_GF16  = 5'h13;

    // MSB-first shift-and-reduce over w bits; w <= 16.
    function automatic logic [15:0] gf_mul(input logic [15:0] a, input logic [15:0] b,
                                           input logic [16:0] ply, input int w);
        logic [16:0] acc;
        acc = '0;
        for (int i = 15; i >= 0; i--) begin
            if (i < w) begin
                acc = acc << 1;
                if (acc[w]) acc = acc ^ ply;
                if (b[i]) acc = acc ^ {1'b0, a};
            end
        end
        return acc[15:0];
    endfunction

    // g(x) = prod_{k<n} (x + alpha^k), packed g_0..g_{n-1} with g_0 at the LSBs.
    function automatic logic [511:0] rs_gen(input int w, input int n, input logic [16:0] ply);
        logic [15:0]  g [0:32];
        logic [15:0]  root;
        logic [511:0] pk;
        for (int j = 0; j <= 32; j++) g[j] = '0;
        g[0] = 16'd1;
        root = 16'd1;
        for (int k = 0; k < 32; k++) begin
            if (k < n) begin
                for (int j = 32; j >= 1; j--) g[j] = g[j-1] ^ gf_mul(g[j], root, ply, w);
                g[0] = gf_mul(g[0], root, ply, w);
                root = gf_mul(root, 16'd2, ply, w);
            end
        end
        pk = '0;
        for (int j = 0; j < 32; j++) begin
            if (j < n) pk = pk | (512'(g[j]) << (j * w));
        end
        return pk;
    endfunction

    localparam logic [127:0] RS_GEN_255_239 = 128'(rs_gen(8, 16, 17'h11D));

endpackage

// File: rtl/rs_parity_lfsr_gf_const_mul.sv
// Multiply a GF(2^SYM_W) symbol by a fixed coefficient; constant folding
// reduces this to an XOR network.
module rs_parity_lfsr_gf_const_mul
    import rs_parity_lfsr_pkg::*;
#(
    parameter int               SYM_W     = 8,
    parameter logic [SYM_W:0]   FIELD_PLY = 9'h11D,
    parameter logic [SYM_W-1:0] COEF      = '0
) (
    input  logic [SYM_W-1:0] a,
    output logic [SYM_W-1:0] y
);

    assign y = SYM_W'(gf_mul(16'(a), 16'(COEF), 17'(FIELD_PLY), SYM_W));

endmodule

// File: rtl/rs_parity_lfsr.sv
// Systematic RS encoder: passes K_MSG message symbols through while dividing by
// g(x) in an N_PAR-stage remainder chain, then drains the N_PAR parity symbols.
module rs_parity_lfsr
    import rs_parity_lfsr_pkg::*;
#(
    parameter int                     SYM_W     = 8,
    parameter int                     N_PAR     = 16,
    parameter int                     K_MSG     = 239,
    parameter logic [SYM_W:0]         FIELD_PLY = 9'h11D,
    parameter logic [N_PAR*SYM_W-1:0] GEN_COEF  = RS_GEN_255_239
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [SYM_W-1:0] s_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [SYM_W-1:0] m_data,
    output logic             m_last
);

    localparam int CNT_MAX = (K_MSG > N_PAR) ? K_MSG : N_PAR;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    rs_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SYM_W-1:0] r_q [N_PAR];
    logic [SYM_W-1:0] r_d [N_PAR];
    logic             m_valid_q, m_valid_d;
    logic [SYM_W-1:0] m_data_q, m_data_d;
    logic             m_last_q, m_last_d;

    logic             adv;
    logic             accept;
    logic [SYM_W-1:0] fb;
    logic [SYM_W-1:0] fbm [N_PAR];

    assign fb = s_data ^ r_q[N_PAR-1];

    for (genvar i = 0; i < N_PAR; i++) begin : g_mul
        rs_parity_lfsr_gf_const_mul #(
            .SYM_W    (SYM_W),
            .FIELD_PLY(FIELD_PLY),
            .COEF     (GEN_COEF[i*SYM_W +: SYM_W])
        ) u_mul (
            .a(fb),
            .y(fbm[i])
        );
    end

    always_comb begin
        adv       = ~m_valid_q | m_ready;
        s_ready   = (state_q == ST_MSG) & adv & ~clr;
        accept    = s_valid & s_ready;
        state_d   = state_q;
        cnt_d     = cnt_q;
        r_d       = r_q;
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        m_last_d  = m_last_q;

        // Abort wins over any handshake; the pending output beat is discarded.
        if (clr) begin
            for (int i = 0; i < N_PAR; i++) r_d[i] = '0;
            cnt_d     = '0;
            state_d   = ST_MSG;
            m_valid_d = 1'b0;
            m_last_d  = 1'b0;
        end else begin
            case (state_q)
                ST_MSG: begin
                    if (accept) begin
                        r_d[0] = fbm[0];
                        for (int i = 1; i < N_PAR; i++) r_d[i] = r_q[i-1] ^ fbm[i];
                        m_data_d  = s_data;
                        m_valid_d = 1'b1;
                        m_last_d  = 1'b0;
                        if (cnt_q == CNT_W'(K_MSG - 1)) begin
                            state_d = ST_PAR;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end else if (adv) begin
                        m_valid_d = 1'b0;
                    end
                end
                ST_PAR: begin
                    // Shifting zeros in leaves the chain clear for the next frame.
                    if (adv) begin
                        m_data_d = r_q[N_PAR-1];
                        for (int i = N_PAR - 1; i > 0; i--) r_d[i] = r_q[i-1];
                        r_d[0]    = '0;
                        m_valid_d = 1'b1;
                        m_last_d  = (cnt_q == CNT_W'(N_PAR - 1));
                        if (cnt_q == CNT_W'(N_PAR - 1)) begin
                            state_d = ST_MSG;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                default: state_d = ST_MSG;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_MSG;
            cnt_q     <= '0;
            for (int i = 0; i < N_PAR; i++) r_q[i] <= '0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_last_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            for (int i = 0; i < N_PAR; i++) r_q[i] <= r_d[i];
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            m_last_q  <= m_last_d;
        end
    end

    assign m_valid = m_valid_q;
    assign m_data  = m_data_q;
    assign m_last  = m_last_q;

endmodule

// File: tb/tb_rs_parity_lfsr.sv
// Bench for rs_parity_lfsr: a small GF(16) instance with a hand-worked codeword and
// the default RS(255,239) instance checked against a long-division scoreboard.
module tb_rs_parity_lfsr;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // default RS(255,239) instance
    logic       clr = 1'b0;
    logic       s_valid = 1'b0;
    logic       s_ready;
    logic [7:0] s_data = '0;
    logic       m_valid;
    logic       m_ready = 1'b1;
    logic [7:0] m_data;
    logic       m_last;

    // GF(16) instance, n=5 k=3
    logic       t1_clr = 1'b0;
    logic       t1_s_valid = 1'b0;
    logic       t1_s_ready;
    logic [3:0] t1_s_data = '0;
    logic       t1_m_valid;
    logic       t1_m_ready = 1'b1;
    logic [3:0] t1_m_data;
    logic       t1_m_last;

    rs_parity_lfsr u_dut (
        .clk(clk), .rst(rst), .clr(clr),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last)
    );

    rs_parity_lfsr #(
        .SYM_W(4), .N_PAR(2), .K_MSG(3), .FIELD_PLY(5'h13), .GEN_COEF({4'h3, 4'h2})
    ) u_dut_t1 (
        .clk(clk), .rst(rst), .clr(t1_clr),
        .s_valid(t1_s_valid), .s_ready(t1_s_ready), .s_data(t1_s_data),
        .m_valid(t1_m_valid), .m_ready(t1_m_ready), .m_data(t1_m_data), .m_last(t1_m_last)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // LSB-first multiply in GF(256) mod 0x11D
    function automatic logic [7:0] tb_gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1D) : (x << 1);
        end
        return p;
    endfunction

    logic [7:0] g_tb [0:16];
    logic [8:0] exp_q [$];
    bit         rnd_ready = 1'b0;

    // Scoreboard: pop one expected {last,data} per beat that will transfer on the next edge.
    always @(negedge clk) begin
        if (!rst && !clr && m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
                check("extra_beat", m_data, 32'h1ff);
            end else begin
                logic [8:0] e;
                e = exp_q.pop_front();
                check("cw_data", m_data, e[7:0]);
                check("cw_last", m_last, e[8]);
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #2;
            m_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    logic [3:0] t1_seen_d [0:7];
    logic       t1_seen_l [0:7];
    int         t1_n = 0;
    always @(negedge clk) begin
        if (!rst && t1_m_valid && t1_m_ready && t1_n < 8) begin
            t1_seen_d[t1_n] = t1_m_data;
            t1_seen_l[t1_n] = t1_m_last;
            t1_n++;
        end
    end

    task automatic send_sym(input logic [7:0] d);
        bit acc;
        int guard;
        acc   = 1'b0;
        guard = 0;
        s_valid = 1'b1;
        s_data  = d;
        while (!acc && guard < 1000) begin
            @(negedge clk);
            acc = s_ready;
            @(posedge clk);
            #1;
            guard++;
        end
        s_valid = 1'b0;
        if (!acc) check("accept_timeout", 32'd0, 32'd1);
    endtask

    // kind 0: all zero, 1: zeros then 0x01 (parity = g), 2: random
    task automatic run_frame(input int kind, input int abort_at, input bit gaps);
        logic [7:0] msg [0:238];
        logic [7:0] c   [0:254];
        logic [7:0] coef;
        for (int i = 0; i < 239; i++) begin
            case (kind)
                0:       msg[i] = 8'h00;
                1:       msg[i] = (i == 238) ? 8'h01 : 8'h00;
                default: msg[i] = 8'($urandom_range(0, 255));
            endcase
        end
        for (int i = 0; i < 255; i++) c[i] = (i < 239) ? msg[i] : 8'h00;
        for (int i = 0; i < 239; i++) begin
            coef = c[i];
            for (int j = 1; j <= 16; j++) c[i+j] = c[i+j] ^ tb_gmul(coef, g_tb[16-j]);
        end
        for (int i = 0; i < 239; i++) exp_q.push_back({1'b0, msg[i]});
        for (int j = 0; j < 16; j++) begin
            if (kind == 1) exp_q.push_back({(j == 15), g_tb[15-j]});
            else           exp_q.push_back({(j == 15), c[239+j]});
        end
        for (int i = 0; i < 239; i++) begin
            if (i == abort_at) begin
                clr = 1'b1;
                @(posedge clk);
                #1;
                clr = 1'b0;
                exp_q.delete();
                check("clr_m_valid", m_valid, 1'b0);
                check("clr_m_last", m_last, 1'b0);
                return;
            end
            if (gaps && $urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) begin
                @(posedge clk);
                #1;
            end
            send_sym(msg[i]);
        end
    endtask

    task automatic drain(input string tag);
        int guard;
        guard = 0;
        while (exp_q.size() != 0 && guard < 3000) begin
            @(posedge clk);
            #1;
            guard++;
        end
        check(tag, exp_q.size(), 0);
    endtask

    initial begin
        g_tb[0] = 8'h01;
        for (int j = 1; j <= 16; j++) g_tb[j] = 8'h00;
        begin
            logic [7:0] root;
            root = 8'h01;
            for (int k = 0; k < 16; k++) begin
                for (int j = 16; j >= 1; j--) g_tb[j] = g_tb[j-1] ^ tb_gmul(g_tb[j], root);
                g_tb[0] = tb_gmul(g_tb[0], root);
                root = tb_gmul(root, 8'h02);
            end
        end

        repeat (3) @(posedge clk);
        #1;
        check("rst_m_valid", m_valid, 1'b0);
        check("rst_m_data", m_data, 8'h00);
        check("rst_m_last", m_last, 1'b0);
        check("rst_t1_m_valid", t1_m_valid, 1'b0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("idle_s_ready", s_ready, 1'b1);

        // T1: GF(16), message 0,0,1 -> 0,0,1,3,2
        begin
            logic [3:0] t1_msg [0:2];
            logic [3:0] t1_exp [0:4];
            t1_msg = '{4'h0, 4'h0, 4'h1};
            t1_exp = '{4'h0, 4'h0, 4'h1, 4'h3, 4'h2};
            t1_s_valid = 1'b1;
            for (int i = 0; i < 3; i++) begin
                t1_s_data = t1_msg[i];
                @(posedge clk);
                #1;
            end
            t1_s_valid = 1'b0;
            repeat (4) @(posedge clk);
            #1;
            check("t1_count", t1_n, 5);
            for (int i = 0; i < 5; i++) begin
                check("t1_data", t1_seen_d[i], t1_exp[i]);
                check("t1_last", t1_seen_l[i], (i == 4));
            end
        end

        // T2: all-zero codeword
        run_frame(0, -1, 1'b0);
        drain("t2_drain");

        // T3: x^16 mod g gives g itself, then a back-to-back random frame
        run_frame(1, -1, 1'b0);
        run_frame(2, -1, 1'b0);
        drain("t3_drain");

        // T4: backpressure and input gaps
        rnd_ready = 1'b1;
        for (int f = 0; f < 3; f++) run_frame(2, -1, 1'b1);
        drain("t4_drain");
        rnd_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // T5: abort at message symbol 100, then a clean frame
        run_frame(2, 100, 1'b0);
        run_frame(2, -1, 1'b0);
        drain("t5_drain");

        // T6: async reset while draining parity
        run_frame(2, -1, 1'b0);
        repeat (4) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("t6_m_valid", m_valid, 1'b0);
        check("t6_m_data", m_data, 8'h00);
        check("t6_m_last", m_last, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        check("t6_s_ready", s_ready, 1'b1);
        run_frame(2, -1, 1'b0);
        drain("t6_drain");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
